// File: rtl/encode8_rr_pkg.sv
// Shared sizes, FSM encoding and a bit-count helper for the encode8_rr arbiter.
package encode8_pkg;

  localparam int N_SRC = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  function automatic logic [IDX_W:0] popcount8(input logic [N_SRC-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N_SRC; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/encode8_rr_pick8.sv
// Wrapped priority search: first set bit of vec_i scanning start_i..7, 0..start_i-1.
module rr_pick8
  import encode8_pkg::*;
(
  input  logic [N_SRC-1:0] vec_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [IDX_W-1:0] index_o,
  output logic             found_o
);

  logic [N_SRC-1:0] rot;
  logic [IDX_W-1:0] offset;
  logic             found;

  // Rotate so that the start position lands on bit 0; wrap falls out of 3-bit addition.
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_rot
      assign rot[gi] = vec_i[start_i + IDX_W'(gi)];
    end
  endgenerate

  always_comb begin
    offset = '0;
    found  = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found  = 1'b1;
        offset = IDX_W'(i);
      end
    end
  end

  assign index_o = start_i + offset;
  assign found_o = found;

endmodule

// File: rtl/encode8_rr.sv
// Sticky 8-source request encoder with registered index/valid offer, round-robin
// or fixed-priority selection and a saturating count of coalesced (dropped) requests.
module encode8_rr
  import encode8_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             clear,
  input  logic             ack,
  output logic [IDX_W-1:0] index_out,
  output logic             valid,
  output logic [N_SRC-1:0] pending,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, ptr_upd;
  logic             valid_q, valid_d;
  logic [N_SRC-1:0] pend_q, pend_d, pend_upd;
  logic [N_SRC-1:0] ack_mask, drop_vec;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W:0]   drop_sum;
  logic             accept;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;

  assign accept   = valid_q & ack & ~clear;
  assign ack_mask = accept ? (N_SRC'(1) << index_q) : '0;
  // A request arriving on the bit being acknowledged re-arms it rather than being lost.
  assign pend_upd = (pend_q & ~ack_mask) | req;
  assign drop_vec = req & pend_q & ~ack_mask;
  assign drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(popcount8(drop_vec));
  assign ptr_upd  = (ROUND_ROBIN != 0 && accept) ? index_q + 1'b1 : ptr_q;

  rr_pick8 u_pick (
    .vec_i   (pend_upd),
    .start_i (ptr_upd),
    .index_o (pick_idx),
    .found_o (pick_found)
  );

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    pend_d  = pend_upd;
    ptr_d   = ptr_upd;
    drop_d  = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_OFFER;
          index_d = pick_idx;
        end
      end
      ST_OFFER: begin
        if (accept) begin
          if (pick_found) index_d = pick_idx;
          else            state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      index_d = index_q;
      pend_d  = '0;
      ptr_d   = ptr_q;
      drop_d  = drop_q;
    end
    valid_d = (state_d == ST_OFFER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign index_out = index_q;
  assign valid     = valid_q;
  assign pending   = pend_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_encode8_rr.sv
// Scoreboard bench: a round-robin and a fixed-priority instance share stimulus and
// are each compared cycle by cycle against a behavioural model, plus directed checks.
module tb_encode8_rr;

  typedef struct {
    bit       v;
    int       idx;
    bit [7:0] pend;
    int       ptr;
    int       drops;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] req = 8'h00;

  logic [2:0] idx_r, idx_f;
  logic       valid_r, valid_f;
  logic [7:0] pend_r, pend_f;
  logic [7:0] drop_r, drop_f;

  int total = 0;
  int bad = 0;

  mstate_t m_r, m_f, e_r, e_f;
  mstate_t q_r[$];
  mstate_t q_f[$];

  always #5 clk = ~clk;

  encode8_rr #(.ROUND_ROBIN(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .req(req), .clear(clear), .ack(ack),
    .index_out(idx_r), .valid(valid_r), .pending(pend_r), .drop_cnt(drop_r)
  );

  encode8_rr #(.ROUND_ROBIN(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .req(req), .clear(clear), .ack(ack),
    .index_out(idx_f), .valid(valid_f), .pending(pend_f), .drop_cnt(drop_f)
  );

  // Reference: requests are a set of sticky flags, an offer is the first flag found
  // walking upward from the rotating start point, drops are re-requests of live flags.
  function automatic mstate_t model_next(mstate_t s, bit rr, logic [7:0] rq,
                                         bit ak, bit clr, bit rstn);
    mstate_t n;
    bit      accepted, acked, hit;
    int      j;
    if (!rstn) begin
      n.v = 0; n.idx = 0; n.pend = 8'h00; n.ptr = 0; n.drops = 0;
      return n;
    end
    n = s;
    if (clr) begin
      n.pend = 8'h00;
      n.v = 0;
      return n;
    end
    accepted = s.v && ak;
    for (int i = 0; i < 8; i++) begin
      acked = accepted && (i == s.idx);
      if (rq[i] && s.pend[i] && !acked) n.drops = n.drops + 1;
      n.pend[i] = rq[i] || (s.pend[i] && !acked);
    end
    if (n.drops > 255) n.drops = 255;
    if (accepted && rr) n.ptr = (s.idx + 1) % 8;
    if (!s.v || accepted) begin
      hit = 0;
      for (int k = 0; k < 8; k++) begin
        j = (n.ptr + k) % 8;
        if (!hit && n.pend[j]) begin
          hit = 1;
          n.idx = j;
        end
      end
      n.v = hit;
    end
    return n;
  endfunction

  task automatic step(input logic [7:0] rq, input bit ak, input bit clr, input bit rstn);
    mstate_t nr, nf;
    req = rq; ack = ak; clear = clr; rst_n = rstn;
    nr = model_next(m_r, 1'b1, rq, ak, clr, rstn);
    nf = model_next(m_f, 1'b0, rq, ak, clr, rstn);
    @(posedge clk);
    #1;
    m_r = nr;
    m_f = nf;
    q_r.push_back(nr);
    q_f.push_back(nf);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  task automatic cmp_snap(input string nm, input mstate_t e, input logic v,
                          input logic [2:0] ix, input logic [7:0] pd, input logic [7:0] dc);
    bit ok;
    total++;
    ok = (v === e.v) && (!e.v || ix === 3'(e.idx)) && (pd === e.pend) && (dc === 8'(e.drops));
    if (!ok) begin
      bad++;
      $display("FAIL %s scoreboard t=%0t: got v=%0b idx=%0d pend=%02h drop=%0d expected v=%0b idx=%0d pend=%02h drop=%0d",
               nm, $time, v, ix, pd, dc, e.v, e.idx, e.pend, e.drops);
    end
  endtask

  always @(negedge clk) begin
    if (q_r.size() > 0) begin
      e_r = q_r.pop_front();
      cmp_snap("rr", e_r, valid_r, idx_r, pend_r, drop_r);
    end
    if (q_f.size() > 0) begin
      e_f = q_f.pop_front();
      cmp_snap("fixed", e_f, valid_f, idx_f, pend_f, drop_f);
    end
  end

  initial begin
    m_r = '{v: 0, idx: 0, pend: 8'h00, ptr: 0, drops: 0};
    m_f = m_r;
    @(posedge clk);
    #1;

    // Reset state
    step(8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("reset_valid", valid_r, 0);
    chk("reset_index", idx_r, 0);
    chk("reset_pending", pend_r, 0);
    chk("reset_drop", drop_r, 0);

    // Reset mid-offer
    step(8'h10, 1'b0, 1'b0, 1'b1);
    chk("offer_idx4", idx_r, 4);
    chk("offer_valid", valid_r, 1);
    step(8'h20, 1'b0, 1'b0, 1'b1);
    chk("offer_hold_idx", idx_r, 4);
    step(8'h00, 1'b1, 1'b0, 1'b0);
    chk("midrst_valid", valid_r, 0);
    chk("midrst_pending", pend_r, 0);
    chk("midrst_drop", drop_r, 0);
    step(8'h01, 1'b0, 1'b0, 1'b1);
    chk("postrst_valid", valid_r, 1);
    chk("postrst_idx0", idx_r, 0);
    step(8'h00, 1'b0, 1'b0, 1'b0);

    // Pulse 0x24 with ack held: 2 then 5 back-to-back
    step(8'h24, 1'b1, 1'b0, 1'b1);
    chk("rr24_first_idx", idx_r, 2);
    chk("rr24_first_valid", valid_r, 1);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    chk("rr24_second_idx", idx_r, 5);
    chk("rr24_second_valid", valid_r, 1);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    chk("rr24_done_valid", valid_r, 0);
    chk("rr24_done_pending", pend_r, 0);

    // ptr is 6: 0x41 must give 6 then wrap to 0
    step(8'h41, 1'b1, 1'b0, 1'b1);
    chk("wrap_first_idx", idx_r, 6);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    chk("wrap_second_idx", idx_r, 0);
    chk("wrap_second_valid", valid_r, 1);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    chk("wrap_done_valid", valid_r, 0);

    // Fixed priority with 0x81 held: always index 0
    for (int k = 0; k < 6; k++) begin
      step(8'h81, 1'b1, 1'b0, 1'b1);
      chk("fixed_valid", valid_f, 1);
      chk("fixed_idx0", idx_f, 0);
    end
    step(8'h00, 1'b1, 1'b0, 1'b1);
    step(8'h00, 1'b1, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b0);

    // Coalesced pulses while not acknowledged
    step(8'h08, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0, 1'b1);
    chk("drop3_pending", pend_r, 8'h08);
    chk("drop3_cnt", drop_r, 2);
    chk("drop3_idx", idx_r, 3);
    step(8'h08, 1'b1, 1'b0, 1'b1);
    chk("setwins_pending", pend_r, 8'h08);
    chk("setwins_drop", drop_r, 2);
    chk("setwins_valid", valid_r, 1);

    // Clear during an offer with every request line high
    step(8'hFF, 1'b1, 1'b1, 1'b1);
    chk("clear_valid", valid_r, 0);
    chk("clear_pending", pend_r, 0);
    chk("clear_drop", drop_r, 2);

    // Saturation: 300 further drops on bit 0
    step(8'h01, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) step(8'h01, 1'b0, 1'b0, 1'b1);
    chk("sat_drop", drop_r, 255);
    chk("sat_pending", pend_r, 8'h01);
    step(8'h00, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [7:0] rq;
      bit ak, cl, rn;
      rq = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rq = 8'h00;
      ak = ($urandom_range(0, 2) != 0);
      cl = ($urandom_range(0, 40) == 0);
      rn = ($urandom_range(0, 250) != 0);
      step(rq, ak, cl, rn);
    end
    for (int k = 0; k < 10; k++) step(8'h00, 1'b1, 1'b0, 1'b1);

    for (int k = 0; k < 5 && (q_r.size() > 0 || q_f.size() > 0); k++) begin
      @(negedge clk);
      #1;
    end
    total++;
    if (q_r.size() > 0 || q_f.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q_r.size(), q_f.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
